// File: rtl/regfile_tagged.sv
// regfile_tagged
//   Architectural register file with per-register rename state (busy bit and
//   producer ROB tag). Decode/issue reads operands and claims destinations.
//   ROB commit retires values and clears busy only for the newest producer.
//   A flush drops all rename state but keeps the values.
//
// Ports
//   clk_in, rst_n_in      clock, asynchronous active-low reset
//   rdy_in                global ready; low freezes all state
//   flush_pipeline        clear every busy bit and tag (vals kept)
//   rs_reg_id / rs_val / rs_busy / rs_tag
//                         NRD packed combinational read ports
//   is_issuing, issue_rd_id, issue_tag
//                         destination claim
//   is_committing, commit_rd_id, commit_tag, commit_val
//                         retirement write
//
// Configuration
//   REGFILE_COMMIT_BYPASS_EN  forward a same-cycle commit to the read ports.
//                             Left undefined, reads show stored state only.
module regfile_tagged #(
  parameter int XLEN     = 32,
  parameter int REG_ID_W = 5,
  parameter int TAG_W    = 4,
  parameter int NRD      = 2
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    rdy_in,
  input  logic                    flush_pipeline,
  input  logic [NRD*REG_ID_W-1:0] rs_reg_id,
  output logic [NRD*XLEN-1:0]     rs_val,
  output logic [NRD-1:0]          rs_busy,
  output logic [NRD*TAG_W-1:0]    rs_tag,
  input  logic                    is_issuing,
  input  logic [REG_ID_W-1:0]     issue_rd_id,
  input  logic [TAG_W-1:0]        issue_tag,
  input  logic                    is_committing,
  input  logic [REG_ID_W-1:0]     commit_rd_id,
  input  logic [TAG_W-1:0]        commit_tag,
  input  logic [XLEN-1:0]         commit_val
);

  localparam int NREG = 2**REG_ID_W;

  logic [NREG-1:0][XLEN-1:0]  val_q,  val_d;
  logic [NREG-1:0]            busy_q, busy_d;
  logic [NREG-1:0][TAG_W-1:0] tag_q,  tag_d;

  // Register 0 is never written, so its state stays at the reset value of 0.
  logic commit_we, issue_we;
  assign commit_we = is_committing && (commit_rd_id != '0);
  assign issue_we  = is_issuing    && (issue_rd_id  != '0);

  always_comb begin
    val_d  = val_q;
    busy_d = busy_q;
    tag_d  = tag_q;
    if (rdy_in) begin
      if (commit_we) begin
        val_d[commit_rd_id] = commit_val;
        // Only the newest producer may release the register; compare against
        // the tag held before this edge, never the incoming issue_tag.
        if (tag_q[commit_rd_id] == commit_tag)
          busy_d[commit_rd_id] = 1'b0;
      end
      // Issue is applied after commit so a same-register claim wins.
      if (flush_pipeline) begin
        busy_d = '0;
        tag_d  = '0;
      end else if (issue_we) begin
        busy_d[issue_rd_id] = 1'b1;
        tag_d[issue_rd_id]  = issue_tag;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      val_q  <= '0;
      busy_q <= '0;
      tag_q  <= '0;
    end else begin
      val_q  <= val_d;
      busy_q <= busy_d;
      tag_q  <= tag_d;
    end
  end

  // Read ports: combinational from stored state, optionally with commit bypass.
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [REG_ID_W-1:0] id;
    assign id = rs_reg_id[k*REG_ID_W +: REG_ID_W];

`ifdef REGFILE_COMMIT_BYPASS_EN
    logic hit, tmatch;
    // Gated by reset so ports read 0 while reset is held.
    assign hit    = rst_n_in && rdy_in && commit_we && (commit_rd_id == id);
    assign tmatch = (tag_q[id] == commit_tag);
    assign rs_val[k*XLEN +: XLEN] = hit ? commit_val : val_q[id];
    assign rs_busy[k]             = busy_q[id] && !(hit && tmatch);
`else
    assign rs_val[k*XLEN +: XLEN] = val_q[id];
    assign rs_busy[k]             = busy_q[id];
`endif

    assign rs_tag[k*TAG_W +: TAG_W] = rs_busy[k] ? tag_q[id] : '0;
  end

endmodule

// File: tb/tb_regfile_tagged.sv
// Self-checking bench for regfile_tagged: directed scenarios followed by a
// randomized run checked against an array-based reference model.
module tb_regfile_tagged;
  localparam int XLEN = 32, REG_ID_W = 5, TAG_W = 4, NRD = 2;
  localparam int NREG = 2**REG_ID_W;

  logic                    clk_in = 1'b0;
  logic                    rst_n_in;
  logic                    rdy_in;
  logic                    flush_pipeline;
  logic [NRD*REG_ID_W-1:0] rs_reg_id;
  logic [NRD*XLEN-1:0]     rs_val;
  logic [NRD-1:0]          rs_busy;
  logic [NRD*TAG_W-1:0]    rs_tag;
  logic                    is_issuing;
  logic [REG_ID_W-1:0]     issue_rd_id;
  logic [TAG_W-1:0]        issue_tag;
  logic                    is_committing;
  logic [REG_ID_W-1:0]     commit_rd_id;
  logic [TAG_W-1:0]        commit_tag;
  logic [XLEN-1:0]         commit_val;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: architectural value, busy flag, newest producer tag.
  logic [XLEN-1:0]  mval  [NREG];
  logic             mbusy [NREG];
  logic [TAG_W-1:0] mtag  [NREG];

  regfile_tagged #(.XLEN(XLEN), .REG_ID_W(REG_ID_W), .TAG_W(TAG_W), .NRD(NRD)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .flush_pipeline(flush_pipeline),
    .rs_reg_id(rs_reg_id), .rs_val(rs_val), .rs_busy(rs_busy), .rs_tag(rs_tag),
    .is_issuing(is_issuing), .issue_rd_id(issue_rd_id), .issue_tag(issue_tag),
    .is_committing(is_committing), .commit_rd_id(commit_rd_id),
    .commit_tag(commit_tag), .commit_val(commit_val)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [XLEN-1:0] pval(input int k);
    return rs_val[k*XLEN +: XLEN];
  endfunction
  function automatic logic [TAG_W-1:0] ptag(input int k);
    return rs_tag[k*TAG_W +: TAG_W];
  endfunction

  task automatic set_rd(input int k, input int id);
    rs_reg_id[k*REG_ID_W +: REG_ID_W] = id[REG_ID_W-1:0];
  endtask

  task automatic model_clear();
    for (int i = 0; i < NREG; i++) begin
      mval[i] = '0; mbusy[i] = 1'b0; mtag[i] = '0;
    end
  endtask

  task automatic idle();
    rdy_in = 1'b1; flush_pipeline = 1'b0;
    is_issuing = 1'b0; issue_rd_id = '0; issue_tag = '0;
    is_committing = 1'b0; commit_rd_id = '0; commit_tag = '0; commit_val = '0;
  endtask

  // One clock: update the model from the rules of the register file using
  // the inputs present at the edge, then return controls to idle.
  task automatic tick();
    bit match;
    @(posedge clk_in);
    if (!rst_n_in) model_clear();
    else if (rdy_in) begin
      match = (mtag[commit_rd_id] == commit_tag);
      if (is_committing && commit_rd_id != 0) begin
        mval[commit_rd_id] = commit_val;
        if (match) mbusy[commit_rd_id] = 1'b0;
      end
      if (flush_pipeline) begin
        for (int i = 0; i < NREG; i++) begin mbusy[i] = 1'b0; mtag[i] = '0; end
      end else if (is_issuing && issue_rd_id != 0) begin
        mbusy[issue_rd_id] = 1'b1;
        mtag[issue_rd_id]  = issue_tag;
      end
    end
    #1;
    idle();
    #1;
  endtask

  task automatic issue(input int rd, input int tag);
    is_issuing = 1'b1; issue_rd_id = rd[REG_ID_W-1:0]; issue_tag = tag[TAG_W-1:0];
    tick();
  endtask

  task automatic commit(input int rd, input int tag, input logic [XLEN-1:0] v);
    is_committing = 1'b1; commit_rd_id = rd[REG_ID_W-1:0];
    commit_tag = tag[TAG_W-1:0]; commit_val = v;
    tick();
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0; idle(); model_clear();
    set_rd(0, 5); set_rd(1, 9);
    is_committing = 1'b1; commit_rd_id = 5'd5; commit_tag = 4'd1; commit_val = 32'hFFFF;
    #1;
    tick();
    is_committing = 1'b1; commit_rd_id = 5'd9; commit_tag = 4'd0; commit_val = 32'h1111;
    tick();
    for (int k = 0; k < NRD; k++) begin
      n_checks++;
      if (pval(k) !== '0 || rs_busy[k] !== 1'b0 || ptag(k) !== '0) begin
        n_fail++;
        $display("FAIL reset_hold port%0d: val=%h busy=%b tag=%h, want 0/0/0", k, pval(k), rs_busy[k], ptag(k));
      end
    end
    @(negedge clk_in); rst_n_in = 1'b1; #1;
    commit(5, 0, 32'h1234);
    n_checks++;
    if (pval(0) !== 32'h1234 || rs_busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_commit: val=%h busy=%b, want 00001234/0", pval(0), rs_busy[0]);
    end
  endtask

  task automatic test_rename_retire();
    set_rd(0, 3);
    issue(3, 7);
    n_checks++;
    if (rs_busy[0] !== 1'b1 || ptag(0) !== 4'd7) begin
      n_fail++;
      $display("FAIL rename_issue: busy=%b tag=%h, want 1/7", rs_busy[0], ptag(0));
    end
    commit(3, 7, 32'hAA);
    n_checks++;
    if (pval(0) !== 32'hAA || rs_busy[0] !== 1'b0 || ptag(0) !== '0) begin
      n_fail++;
      $display("FAIL rename_retire: val=%h busy=%b tag=%h, want aa/0/0", pval(0), rs_busy[0], ptag(0));
    end
  endtask

  task automatic test_stale_commit();
    set_rd(1, 3);
    issue(3, 2);
    issue(3, 9);
    commit(3, 2, 32'h55);
    n_checks++;
    if (pval(1) !== 32'h55 || rs_busy[1] !== 1'b1 || ptag(1) !== 4'd9) begin
      n_fail++;
      $display("FAIL stale_commit: val=%h busy=%b tag=%h, want 55/1/9", pval(1), rs_busy[1], ptag(1));
    end
    commit(3, 9, 32'h66);
    n_checks++;
    if (pval(1) !== 32'h66 || rs_busy[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL newest_commit: val=%h busy=%b, want 66/0", pval(1), rs_busy[1]);
    end
  endtask

  task automatic test_flush();
    logic [XLEN-1:0] v2;
    issue(1, 1); issue(2, 2); issue(4, 4);
    v2 = mval[2];
    flush_pipeline = 1'b1;
    is_issuing = 1'b1; issue_rd_id = 5'd6; issue_tag = 4'd6;
    is_committing = 1'b1; commit_rd_id = 5'd1; commit_tag = 4'd3; commit_val = 32'h77;
    tick();
    for (int r = 1; r <= 6; r++) begin
      set_rd(0, r); #1;
      n_checks++;
      if (rs_busy[0] !== 1'b0 || ptag(0) !== '0) begin
        n_fail++;
        $display("FAIL flush_busy x%0d: busy=%b tag=%h, want 0/0", r, rs_busy[0], ptag(0));
      end
    end
    set_rd(0, 1); set_rd(1, 2); #1;
    n_checks++;
    if (pval(0) !== 32'h77 || pval(1) !== v2) begin
      n_fail++;
      $display("FAIL flush_vals: x1=%h x2=%h, want 77/%h", pval(0), pval(1), v2);
    end
  endtask

  task automatic test_x0_rdy();
    is_issuing = 1'b1; issue_rd_id = '0; issue_tag = 4'd5;
    is_committing = 1'b1; commit_rd_id = '0; commit_tag = 4'd5; commit_val = 32'hDEAD;
    set_rd(0, 0); #1;
    n_checks++;
    if (pval(0) !== '0 || rs_busy[0] !== 1'b0 || ptag(0) !== '0) begin
      n_fail++;
      $display("FAIL x0_same_cycle: val=%h busy=%b tag=%h, want 0/0/0", pval(0), rs_busy[0], ptag(0));
    end
    tick();
    n_checks++;
    if (pval(0) !== '0 || rs_busy[0] !== 1'b0 || ptag(0) !== '0) begin
      n_fail++;
      $display("FAIL x0_after: val=%h busy=%b tag=%h, want 0/0/0", pval(0), rs_busy[0], ptag(0));
    end
    rdy_in = 1'b0;
    is_issuing = 1'b1; issue_rd_id = 5'd8; issue_tag = 4'd6;
    is_committing = 1'b1; commit_rd_id = 5'd8; commit_tag = 4'd0; commit_val = 32'h99;
    set_rd(1, 8); #1;
    n_checks++;
    if (pval(1) !== '0 || rs_busy[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL rdy_low_read: val=%h busy=%b, want 0/0", pval(1), rs_busy[1]);
    end
    tick();
    n_checks++;
    if (pval(1) !== '0 || rs_busy[1] !== 1'b0 || ptag(1) !== '0) begin
      n_fail++;
      $display("FAIL rdy_low_hold: val=%h busy=%b tag=%h, want 0/0/0", pval(1), rs_busy[1], ptag(1));
    end
  endtask

  task automatic test_same_cycle();
    logic [XLEN-1:0] old;
    issue(5, 3);
    old = mval[5];
    set_rd(0, 5);
    is_committing = 1'b1; commit_rd_id = 5'd5; commit_tag = 4'd3; commit_val = 32'hBEEF;
    #1;
    n_checks++;
`ifdef REGFILE_COMMIT_BYPASS_EN
    if (pval(0) !== 32'hBEEF || rs_busy[0] !== 1'b0 || ptag(0) !== '0) begin
      n_fail++;
      $display("FAIL bypass_same_cycle: val=%h busy=%b tag=%h, want beef/0/0", pval(0), rs_busy[0], ptag(0));
    end
`else
    if (pval(0) !== old || rs_busy[0] !== 1'b1 || ptag(0) !== 4'd3) begin
      n_fail++;
      $display("FAIL legacy_same_cycle: val=%h busy=%b tag=%h, want %h/1/3", pval(0), rs_busy[0], ptag(0), old);
    end
`endif
    tick();
    n_checks++;
    if (pval(0) !== 32'hBEEF || rs_busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL same_cycle_next: val=%h busy=%b, want beef/0", pval(0), rs_busy[0]);
    end
  endtask

  task automatic test_random();
    int rid [NRD];
    logic [XLEN-1:0]  ev;
    logic             eb;
    logic [TAG_W-1:0] et;
    for (int c = 0; c < 400; c++) begin
      if (c == 200) begin
        // Mid-run asynchronous reset with live traffic.
        rst_n_in = 1'b0; model_clear();
        is_committing = 1'b1; commit_rd_id = 5'd7; commit_tag = '0; commit_val = 32'h5A5A;
        set_rd(0, 7); set_rd(1, 3); #1;
        n_checks++;
        if (rs_val !== '0 || rs_busy !== '0 || rs_tag !== '0) begin
          n_fail++;
          $display("FAIL midrun_reset: val=%h busy=%b tag=%h, want 0", rs_val, rs_busy, rs_tag);
        end
        tick();
        @(negedge clk_in); rst_n_in = 1'b1; #1;
      end
      rdy_in         = ($urandom_range(9) != 0);
      flush_pipeline = ($urandom_range(19) == 0);
      is_issuing     = ($urandom_range(9) < 6);
      issue_rd_id    = REG_ID_W'($urandom_range(7));
      issue_tag      = TAG_W'($urandom);
      is_committing  = ($urandom_range(9) < 6);
      commit_rd_id   = REG_ID_W'($urandom_range(7));
      // Favour the tag actually in flight so retirements do happen.
      commit_tag     = ($urandom_range(1) == 0) ? mtag[commit_rd_id] : TAG_W'($urandom);
      commit_val     = $urandom;
      for (int k = 0; k < NRD; k++) begin
        rid[k] = (k == 0 && $urandom_range(2) == 0) ? int'(commit_rd_id) : int'($urandom_range(7));
        set_rd(k, rid[k]);
      end
      #1;
      for (int k = 0; k < NRD; k++) begin
        ev = mval[rid[k]]; eb = mbusy[rid[k]]; et = mtag[rid[k]];
`ifdef REGFILE_COMMIT_BYPASS_EN
        if (rdy_in && is_committing && int'(commit_rd_id) == rid[k] && rid[k] != 0) begin
          ev = commit_val;
          if (mtag[rid[k]] == commit_tag) eb = 1'b0;
        end
`endif
        if (!eb) et = '0;
        n_checks++;
        if (pval(k) !== ev || rs_busy[k] !== eb || ptag(k) !== et) begin
          n_fail++;
          $display("FAIL random c%0d port%0d x%0d: got %h/%b/%h, want %h/%b/%h",
                   c, k, rid[k], pval(k), rs_busy[k], ptag(k), ev, eb, et);
        end
      end
      tick();
    end
  endtask

  initial begin
    rs_reg_id = '0;
    test_reset();
    test_rename_retire();
    test_stale_commit();
    test_flush();
    test_x0_rdy();
    test_same_cycle();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
